// File: rtl/condicionador_botoes_pkg.sv
// Shared definitions for the button-conditioning stage and the digit FSM
// that consumes its commands.
package condicionador_botoes_pkg;

  // Command codes seen by the FSM on `entradas`.
  localparam logic [1:0] CMD_NADA   = 2'b00;
  localparam logic [1:0] CMD_AVANCA = 2'b01;
  localparam logic [1:0] CMD_VOLTA  = 2'b10;
  localparam logic [1:0] CMD_APAGA  = 2'b11;

  // Per-button debounce states.
  typedef enum logic [1:0] {
    StSolto       = 2'b00,
    StConfPress   = 2'b01,
    StPressionado = 2'b10,
    StConfSolto   = 2'b11
  } deb_state_e;

endpackage

// File: rtl/debounce_botao.sv
// Synchronizer, debounce FSM and single-cycle press pulse for one raw
// active-low push-button.
module debounce_botao
  import condicionador_botoes_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CICLOS = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic botao_ni,
  output logic pulso_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CICLOS) + 1;
  localparam logic [CntW-1:0] CntFim = CntW'(DEBOUNCE_CICLOS - 1);

  logic            sync1_q, sync2_q;
  deb_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pulso_q, pulso_d;

  // Two-flop synchronizer; resets to the released level.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= botao_ni;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next state: a level change is accepted only after it has
  // been stable for DEBOUNCE_CICLOS consecutive cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulso_d = 1'b0;
    unique case (state_q)
      StSolto: begin
        if (!sync2_q) begin
          state_d = StConfPress;
          cnt_d   = CntW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      StConfPress: begin
        if (sync2_q) begin
          // Glitch: back to released without a pulse.
          state_d = StSolto;
          cnt_d   = '0;
        end else if (cnt_q == CntFim) begin
          state_d = StPressionado;
          cnt_d   = '0;
          pulso_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPressionado: begin
        if (sync2_q) begin
          state_d = StConfSolto;
          cnt_d   = CntW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      StConfSolto: begin
        if (!sync2_q) begin
          state_d = StPressionado;
          cnt_d   = '0;
        end else if (cnt_q == CntFim) begin
          state_d = StSolto;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StSolto;
        cnt_d   = '0;
      end
    endcase
  end

  // Debounce state, counter and registered press pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StSolto;
      cnt_q   <= '0;
      pulso_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulso_q <= pulso_d;
    end
  end

  assign pulso_o = pulso_q;

endmodule

// File: rtl/condicionador_botoes.sv
// Button conditioning for the digit-sequencing FSM: debounced press pulses
// are accumulated and issued as one command per step period, with a
// single-cycle strobe.
module condicionador_botoes
  import condicionador_botoes_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CICLOS = 500000,
  parameter int unsigned DIV_CICLOS      = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       bot_avancar,
  input  logic       bot_voltar,
  output logic [1:0] entradas,
  output logic       passo,
  output logic [1:0] pendente
);

  localparam int unsigned DivW = $clog2(DIV_CICLOS);
  localparam logic [DivW-1:0] DivFim = DivW'(DIV_CICLOS - 1);

  logic            pulso_avancar, pulso_voltar;
  logic [1:0]      pulsos;
  logic            carga;
  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      entradas_q, entradas_d;
  logic [1:0]      pendente_q, pendente_d;
  logic            passo_q, passo_d;

  debounce_botao #(
    .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
  ) u_deb_avancar (
    .clock   (clock),
    .reset   (reset),
    .botao_ni(bot_avancar),
    .pulso_o (pulso_avancar)
  );

  debounce_botao #(
    .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
  ) u_deb_voltar (
    .clock   (clock),
    .reset   (reset),
    .botao_ni(bot_voltar),
    .pulso_o (pulso_voltar)
  );

  // Step divider and command accumulator; a pulse arriving on the load
  // edge is folded into the command issued on that edge.
  always_comb begin
    pulsos     = (pulso_avancar ? CMD_AVANCA : CMD_NADA) |
                 (pulso_voltar  ? CMD_VOLTA  : CMD_NADA);
    carga      = (div_q == DivFim);
    div_d      = carga ? '0 : div_q + DivW'(1);
    passo_d    = carga;
    entradas_d = carga ? (pendente_q | pulsos) : entradas_q;
    pendente_d = carga ? CMD_NADA : (pendente_q | pulsos);
  end

  // Divider, accumulator and output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      div_q      <= '0;
      entradas_q <= CMD_NADA;
      pendente_q <= CMD_NADA;
      passo_q    <= 1'b0;
    end else begin
      div_q      <= div_d;
      entradas_q <= entradas_d;
      pendente_q <= pendente_d;
      passo_q    <= passo_d;
    end
  end

  assign entradas = entradas_q;
  assign passo    = passo_q;
  assign pendente = pendente_q;

endmodule
